// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, parity modes and transmitter FSM encoding.
// Also hosts the parity helper so TX and RX agree on the odd/even convention.
package uart_pkg;

    localparam int UART_DW = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input int mode, input logic [UART_DW-1:0] data);
        case (mode)
            PAR_ODD:  return ~^data;
            PAR_EVEN: return ^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-producer side of the UART transmitter: write strobe/data plus FIFO status.
// The producer uses the master modport, the transmitter the slave modport.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 4
);
    import uart_pkg::*;

    logic                   TX_En_Sig;
    logic [UART_DW-1:0]     TX_Data;
    logic                   TX_Ready;
    logic                   TX_Drop;
    logic [$clog2(DEPTH):0] TX_Level;

    modport master (output TX_En_Sig, TX_Data, input TX_Ready, TX_Drop, TX_Level);
    modport slave  (input TX_En_Sig, TX_Data, output TX_Ready, TX_Drop, TX_Level);

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// Circular byte buffer for the UART transmitter; pointers carry a wrap bit so
// full and empty fall straight out of the pointer compare.
module uart_tx_fifo_mem import uart_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                   BPS_CLK,
    input  logic                   RSTn,
    input  logic                   wr_en,
    input  logic [UART_DW-1:0]     wr_data,
    input  logic                   rd_en,
    output logic [UART_DW-1:0]     rd_data,
    output logic                   full,
    output logic                   empty,
    output logic                   drop,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DW-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               push;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign push    = wr_en && !full;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is left unreset; pointers alone define which entries are valid.
    always_ff @(posedge BPS_CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge BPS_CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop   <= 1'b0;
        end else begin
            if (push)            wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
            // Judged on pre-edge fullness, so a same-edge pop does not rescue the write.
            drop <= wr_en && full;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter clocked at the bit rate: start, 8 data bits
// LSB first, optional parity, STOP_BITS stop bits; back-to-back frames without gaps.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DEPTH     = 4,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 2
) (
    input  logic          BPS_CLK,
    input  logic          RSTn,
    uart_tx_fifo_if.slave bus,
    output logic          TX_Pin_Out,
    output logic          TX_Busy,
    output logic          TX_Done_Sig
);

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS);
    localparam logic [3:0] BIT_LAST  = 4'(UART_DW);

    logic [2:0]         state;
    logic [UART_DW-1:0] shreg;
    logic [UART_DW-1:0] head;
    logic [3:0]         bit_idx;
    logic [2:0]         stop_cnt;
    logic               par_bit;
    logic               fifo_full;
    logic               fifo_empty;
    logic               last_stop;
    logic               pop;

    uart_tx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .BPS_CLK (BPS_CLK),
        .RSTn    (RSTn),
        .wr_en   (bus.TX_En_Sig),
        .wr_data (bus.TX_Data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .drop    (bus.TX_Drop),
        .level   (bus.TX_Level)
    );

    assign bus.TX_Ready = !fifo_full;

    // A new frame starts from idle or directly on the edge ending the last stop bit.
    assign last_stop = (state == ST_STOP) && (stop_cnt == STOP_LAST);
    assign pop       = !fifo_empty && ((state == ST_IDLE) || last_stop);

    // NOTE: non-blocking updates so every branch sees the pre-edge shift/count values.
    always_ff @(posedge BPS_CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= ST_IDLE;
            TX_Pin_Out  <= 1'b1;
            TX_Busy     <= 1'b0;
            TX_Done_Sig <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            stop_cnt    <= '0;
            par_bit     <= 1'b0;
        end else begin
            TX_Done_Sig <= last_stop;
            if (pop) begin
                shreg      <= head;
                par_bit    <= parity_bit(PARITY, head);
                TX_Pin_Out <= 1'b0;
                TX_Busy    <= 1'b1;
                state      <= ST_START;
            end else begin
                case (state)
                    ST_START: begin
                        TX_Pin_Out <= shreg[0];
                        shreg      <= {1'b0, shreg[UART_DW-1:1]};
                        bit_idx    <= 4'd1;
                        state      <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_idx == BIT_LAST) begin
                            if (PARITY != PAR_NONE) begin
                                TX_Pin_Out <= par_bit;
                                state      <= ST_PARITY;
                            end else begin
                                TX_Pin_Out <= 1'b1;
                                stop_cnt   <= 3'd1;
                                state      <= ST_STOP;
                            end
                        end else begin
                            TX_Pin_Out <= shreg[0];
                            shreg      <= {1'b0, shreg[UART_DW-1:1]};
                            bit_idx    <= bit_idx + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        TX_Pin_Out <= 1'b1;
                        stop_cnt   <= 3'd1;
                        state      <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (last_stop) begin
                            TX_Pin_Out <= 1'b1;
                            TX_Busy    <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 3'd1;
                        end
                    end
                    default: begin
                        TX_Pin_Out <= 1'b1;
                        TX_Busy    <= 1'b0;
                        state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three parameterisations driven with directed and
// random writes, checked against a frame-level model and a behavioural line receiver.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 4;

    logic BPS_CLK = 1'b0;
    logic RSTn    = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 BPS_CLK = ~BPS_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit k of the result is the line level during the k-th bit time of a frame.
    function automatic logic [15:0] frame_bits(input logic [7:0] b, input int p);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
        if (p != 0) f[9] = logic'(($countones(b) + ((p == 1) ? 1 : 0)) % 2);
        return f;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int P  = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int S  = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int FL = 9 + ((P != 0) ? 1 : 0) + S;

        uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
        logic pin, busy, done;

        uart_tx_fifo #(.DEPTH(DEPTH), .PARITY(P), .STOP_BITS(S)) dut (
            .BPS_CLK     (BPS_CLK),
            .RSTn        (RSTn),
            .bus         (bus),
            .TX_Pin_Out  (pin),
            .TX_Busy     (busy),
            .TX_Done_Sig (done)
        );

        logic [7:0]  mq [$];
        logic [7:0]  sb [$];
        int          m_rem;
        logic [15:0] m_fr;
        logic        m_done, m_drop;
        int          m_pend;
        int          sb_n;

        // Reference model: bytes queue up, each frame lasts FL bit times, the next
        // queued byte starts on the edge where the previous frame ends.
        initial begin
            int         cnt;
            logic [7:0] b;
            m_rem = 0; m_fr = '1; m_done = 0; m_drop = 0; m_pend = 0;
            forever begin
                @(posedge BPS_CLK or negedge RSTn);
                if (!RSTn) begin
                    m_rem = 0; m_done = 0; m_drop = 0;
                    mq.delete();
                    sb.delete();
                end else begin
                    cnt    = mq.size();
                    m_done = 1'b0;
                    if (m_rem > 0) begin
                        m_rem--;
                        m_done = (m_rem == 0);
                    end
                    if (m_rem == 0 && cnt > 0) begin
                        b     = mq.pop_front();
                        m_fr  = frame_bits(b, P);
                        m_rem = FL;
                    end
                    m_drop = bus.TX_En_Sig && (cnt == DEPTH);
                    if (bus.TX_En_Sig && cnt < DEPTH) begin
                        mq.push_back(bus.TX_Data);
                        sb.push_back(bus.TX_Data);
                    end
                end
                m_pend = mq.size() + ((m_rem > 0) ? 1 : 0);
            end
        end

        // Monitor: cycle checks of every output plus a line receiver feeding the scoreboard.
        initial begin
            int          rx_n;
            logic [15:0] rx_v;
            logic [15:0] mask;
            logic [7:0]  rx_b;
            logic        exp_pin;
            rx_n = 0; rx_v = '1; sb_n = 0;
            mask = 16'((32'd1 << FL) - 1);
            forever begin
                @(negedge BPS_CLK);
                exp_pin = (m_rem > 0) ? m_fr[FL-m_rem] : 1'b1;
                check($sformatf("u%0d line", g), pin, exp_pin);
                check($sformatf("u%0d busy", g), busy, m_rem > 0);
                check($sformatf("u%0d done", g), done, m_done);
                check($sformatf("u%0d drop", g), bus.TX_Drop, m_drop);
                check($sformatf("u%0d level", g), bus.TX_Level, mq.size());
                check($sformatf("u%0d ready", g), bus.TX_Ready, mq.size() < DEPTH);
                if (!RSTn) begin
                    rx_n = 0;
                end else if (rx_n == 0) begin
                    if (pin == 1'b0) begin
                        rx_v    = '1;
                        rx_v[0] = 1'b0;
                        rx_n    = 1;
                    end
                end else begin
                    rx_v[rx_n] = pin;
                    if (rx_n == FL - 1) begin
                        rx_b = rx_v[8:1];
                        check($sformatf("u%0d frame", g), rx_v & mask, frame_bits(rx_b, P) & mask);
                        check($sformatf("u%0d sb nonempty", g), sb.size() != 0, 1);
                        if (sb.size() != 0) check($sformatf("u%0d rx byte", g), rx_b, sb.pop_front());
                        rx_n = 0;
                    end else begin
                        rx_n++;
                    end
                end
                sb_n = sb.size();
            end
        end
    end

    task automatic put(input logic [2:0] en, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2);
        u[0].bus.TX_En_Sig = en[0]; u[0].bus.TX_Data = d0;
        u[1].bus.TX_En_Sig = en[1]; u[1].bus.TX_Data = d1;
        u[2].bus.TX_En_Sig = en[2]; u[2].bus.TX_Data = d2;
        @(negedge BPS_CLK);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((u[0].m_pend + u[1].m_pend + u[2].m_pend) != 0 && n < budget) begin
            put(3'b000, 8'h00, 8'h00, 8'h00);
            n++;
        end
        check("drain", u[0].m_pend + u[1].m_pend + u[2].m_pend, 0);
        repeat (2) put(3'b000, 8'h00, 8'h00, 8'h00);
    endtask

    initial begin
        logic [10:0] got;
        logic [7:0]  seq [6];
        u[0].bus.TX_En_Sig = 1'b0; u[0].bus.TX_Data = '0;
        u[1].bus.TX_En_Sig = 1'b0; u[1].bus.TX_Data = '0;
        u[2].bus.TX_En_Sig = 1'b0; u[2].bus.TX_Data = '0;
        repeat (3) @(negedge BPS_CLK);
        RSTn = 1'b1;

        // Quiet line after reset.
        repeat (50) put(3'b000, 8'h00, 8'h00, 8'h00);

        // Single 0xA5 frame on the default instance, against the literal bit sequence.
        put(3'b001, 8'hA5, 8'h00, 8'h00);
        for (int i = 0; i < 11; i++) begin
            put(3'b000, 8'h00, 8'h00, 8'h00);
            got[i] = u[0].pin;
        end
        check("A5 line sequence", got, 11'b11101001010);
        drain(100);

        // Three consecutive writes: contiguous frames.
        put(3'b111, 8'h55, 8'h55, 8'h55);
        put(3'b111, 8'h0F, 8'h0F, 8'h0F);
        put(3'b111, 8'hF0, 8'hF0, 8'hF0);
        drain(200);

        // Six back-to-back writes into a 4-deep FIFO.
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
        for (int i = 0; i < 6; i++) put(3'b111, seq[i], seq[i], seq[i]);
        drain(300);

        // Parity of 0x07: even instance sends 1, odd instance sends 0.
        put(3'b110, 8'h00, 8'h07, 8'h07);
        for (int i = 0; i < 10; i++) put(3'b000, 8'h00, 8'h00, 8'h00);
        check("even parity 07", u[1].pin, 1'b1);
        check("odd parity 07", u[2].pin, 1'b0);
        drain(100);

        // Randomised traffic: dense bursts first, then sparse writes.
        for (int i = 0; i < 600; i++) begin
            logic [2:0] en;
            int         pct;
            pct = (i < 300) ? 70 : 15;
            for (int k = 0; k < 3; k++) en[k] = ($urandom_range(0, 99) < pct);
            put(en, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        drain(500);

        // Reset mid-frame: line must go high without waiting for a clock edge.
        put(3'b111, 8'h00, 8'h00, 8'h00);
        put(3'b111, 8'h3C, 8'h3C, 8'h3C);
        repeat (4) put(3'b000, 8'h00, 8'h00, 8'h00);
        check("pre-reset line low", u[0].pin, 1'b0);
        #2 RSTn = 1'b0;
        #1;
        check("u0 async reset line", u[0].pin, 1'b1);
        check("u1 async reset line", u[1].pin, 1'b1);
        check("u2 async reset line", u[2].pin, 1'b1);
        check("u0 async reset level", u[0].bus.TX_Level, 0);
        check("u2 async reset busy", u[2].busy, 1'b0);
        @(negedge BPS_CLK);
        RSTn = 1'b1;
        repeat (20) put(3'b000, 8'h00, 8'h00, 8'h00);

        // Traffic after reset recovery.
        put(3'b111, 8'hC3, 8'h81, 8'h7E);
        put(3'b111, 8'h18, 8'hFF, 8'h00);
        drain(200);

        check("u0 scoreboard empty", u[0].sb_n, 0);
        check("u1 scoreboard empty", u[1].sb_n, 0);
        check("u2 scoreboard empty", u[2].sb_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
